// File: rtl/ddr3_app_if.sv
// ddr3_app_if: request/response FIFO and MIG app bundle for ddr3_app_scheduler
interface ddr3_app_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int APP_ADDR_WIDTH = 29,
    parameter int DATA_WIDTH     = 128,
    parameter int RSP_FREE_WIDTH = 5
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    logic                      wr_req_empty;
    logic [ADDR_WIDTH-1:0]     wr_req_addr;
    logic [DATA_WIDTH-1:0]     wr_req_data;
    logic [MASK_WIDTH-1:0]     wr_req_be;
    logic                      wr_req_pop;
    logic                      rd_req_empty;
    logic [ADDR_WIDTH-1:0]     rd_req_addr;
    logic                      rd_req_pop;
    logic [RSP_FREE_WIDTH-1:0] rd_rsp_free;
    logic                      rd_rsp_valid;
    logic [ADDR_WIDTH-1:0]     rd_rsp_addr;
    logic [DATA_WIDTH-1:0]     rd_rsp_data;
    logic [APP_ADDR_WIDTH-1:0] app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [DATA_WIDTH-1:0]     app_wdf_data;
    logic [MASK_WIDTH-1:0]     app_wdf_mask;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_wdf_rdy;
    logic [DATA_WIDTH-1:0]     app_rd_data;
    logic                      app_rd_data_valid;

    modport master (
        input  wr_req_empty, wr_req_addr, wr_req_data, wr_req_be,
        input  rd_req_empty, rd_req_addr, rd_rsp_free,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output wr_req_pop, rd_req_pop, rd_rsp_valid, rd_rsp_addr, rd_rsp_data,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
    modport slave (
        output wr_req_empty, wr_req_addr, wr_req_data, wr_req_be,
        output rd_req_empty, rd_req_addr, rd_rsp_free,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  wr_req_pop, rd_req_pop, rd_rsp_valid, rd_rsp_addr, rd_rsp_data,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/ddr3_app_scheduler.sv
// ddr3_app_scheduler: arbitrates FWFT read/write request FIFOs onto the MIG app interface,
// tagging outstanding reads with their address and throttling on response FIFO space.
module ddr3_app_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int APP_ADDR_WIDTH  = 29,
    parameter int DATA_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ARB_MODE        = 0,
    parameter int WR_STARVE_LIMIT = 4,
    parameter int RSP_FREE_WIDTH  = 5,
    localparam int MASK_WIDTH     = DATA_WIDTH / 8,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    ddr3_app_if.master    bus,
    output logic [OW-1:0] outstanding_o,
    output logic          busy_o,
    output logic          protocol_err_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int SW = $clog2(WR_STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_ISSUE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [2:0]                cmd_q, cmd_d;
    logic                      app_en_q, app_en_d, wren_q, wren_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d, rsp_data_q;
    logic [MASK_WIDTH-1:0]     mask_q, mask_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      last_rd_q;
    logic [ADDR_WIDTH-1:0]     tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0]             wptr_q, rptr_q;
    logic [OW-1:0]             out_q;
    logic                      rsp_valid_q, err_q;
    logic [ADDR_WIDTH-1:0]     rsp_addr_q;
    logic [RSP_FREE_WIDTH-1:0] rsp_free;
    logic                      rd_elig, wr_elig, wr_force, idle_en, grant_rd, grant_wr, tag_push, tag_pop;

    assign rsp_free = bus.rd_rsp_free;
    assign rd_elig  = !bus.rd_req_empty && 32'(out_q) < MAX_OUTSTANDING && 32'(out_q) < 32'(rsp_free);
    assign wr_elig  = !bus.wr_req_empty;
    assign wr_force = wr_elig && starve_q == SW'(WR_STARVE_LIMIT);
    assign idle_en  = state_q == IDLE && en_i;
    // mode 1 alternates only when both are eligible; a lone eligible type always wins
    assign grant_rd = idle_en && rd_elig && (ARB_MODE == 0 ? !wr_force : !(wr_elig && last_rd_q));
    assign grant_wr = idle_en && wr_elig && !grant_rd;
    assign tag_push = state_q == RD_ISSUE && bus.app_rdy;
    assign tag_pop  = bus.app_rd_data_valid && out_q != '0;
    assign starve_d = (!wr_elig || grant_wr) ? '0 :
                      (grant_rd && starve_q != SW'(WR_STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        app_en_d = app_en_q;
        wren_d   = wren_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_d  = grant_rd ? RD_ISSUE : WR_ISSUE;
                    addr_d   = grant_rd ? bus.rd_req_addr : bus.wr_req_addr;
                    cmd_d    = grant_rd ? 3'b001 : 3'b000;
                    app_en_d = 1'b1;
                    wren_d   = grant_wr;
                end
                if (grant_wr) begin
                    wdata_d = bus.wr_req_data;
                    mask_d  = ~bus.wr_req_be;
                end
            end
            RD_ISSUE: begin
                app_en_d = !bus.app_rdy;
                state_d  = bus.app_rdy ? IDLE : RD_ISSUE;
            end
            WR_ISSUE: begin
                app_en_d = app_en_q && !bus.app_rdy;
                wren_d   = wren_q && !bus.app_wdf_rdy;
                state_d  = (app_en_d || wren_d) ? WR_ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[wptr_q] <= addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cmd_q       <= '0;
            app_en_q    <= 1'b0;
            wren_q      <= 1'b0;
            wdata_q     <= '0;
            mask_q      <= '0;
            starve_q    <= '0;
            last_rd_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            app_en_q    <= app_en_d;
            wren_q      <= wren_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            starve_q    <= starve_d;
            last_rd_q   <= grant_rd ? 1'b1 : grant_wr ? 1'b0 : last_rd_q;
            wptr_q      <= wptr_q + PW'(tag_push);
            rptr_q      <= rptr_q + PW'(tag_pop);
            out_q       <= out_q + OW'(tag_push) - OW'(tag_pop);
            rsp_valid_q <= tag_pop;
            err_q       <= err_q || (bus.app_rd_data_valid && out_q == '0);
            if (tag_pop) begin
                rsp_addr_q <= tag_mem[rptr_q];
                rsp_data_q <= bus.app_rd_data;
            end
        end
    end

    assign bus.wr_req_pop   = grant_wr;
    assign bus.rd_req_pop   = grant_rd;
    assign bus.rd_rsp_valid = rsp_valid_q;
    assign bus.rd_rsp_addr  = rsp_addr_q;
    assign bus.rd_rsp_data  = rsp_data_q;
    assign bus.app_addr     = addr_q[APP_ADDR_WIDTH-1:0];
    assign bus.app_cmd      = cmd_q;
    assign bus.app_en       = app_en_q;
    assign bus.app_wdf_data = wdata_q;
    assign bus.app_wdf_mask = mask_q;
    assign bus.app_wdf_wren = wren_q;
    assign bus.app_wdf_end  = wren_q;
    assign outstanding_o    = out_q;
    assign busy_o           = state_q != IDLE || out_q != '0;
    assign protocol_err_o   = err_q;
endmodule

// File: tb/tb_ddr3_app_scheduler.sv
// tb_ddr3_app_scheduler: directed checks of a mode-0 and a mode-1 scheduler sharing one stimulus
module tb_ddr3_app_scheduler;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
    always #5 clk = ~clk;

    ddr3_app_if b0();
    ddr3_app_if b1();
    logic [3:0] out0, out1;
    logic busy0, busy1, err0, err1;
    logic rv_man = 1'b0, rv_auto = 1'b0, auto_en = 1'b0;
    logic [15:0] seq0 = '0, seq1 = '0;
    int total = 0, bad = 0, wr_pops = 0, n0 = 0, n1 = 0, base0, base1;

    assign b0.app_rd_data_valid = rv_man | rv_auto;
    assign b1.wr_req_empty      = b0.wr_req_empty;
    assign b1.wr_req_addr       = b0.wr_req_addr;
    assign b1.wr_req_data       = b0.wr_req_data;
    assign b1.wr_req_be         = b0.wr_req_be;
    assign b1.rd_req_empty      = b0.rd_req_empty;
    assign b1.rd_req_addr       = b0.rd_req_addr;
    assign b1.rd_rsp_free       = b0.rd_rsp_free;
    assign b1.app_rdy           = b0.app_rdy;
    assign b1.app_wdf_rdy       = b0.app_wdf_rdy;
    assign b1.app_rd_data       = b0.app_rd_data;
    assign b1.app_rd_data_valid = b0.app_rd_data_valid;

    ddr3_app_scheduler #(.ARB_MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .bus(b0),
        .outstanding_o(out0), .busy_o(busy0), .protocol_err_o(err0)
    );
    ddr3_app_scheduler #(.ARB_MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .bus(b1),
        .outstanding_o(out1), .busy_o(busy1), .protocol_err_o(err1)
    );

    // model MIG: return one beat the cycle after each accepted read on d0
    always @(posedge clk) rv_auto <= auto_en && b0.app_en && b0.app_rdy && b0.app_cmd == 3'b001;

    // grant log: most recent grant in bit 0, 1 = write
    always @(negedge clk) begin
        if (b0.wr_req_pop) wr_pops <= wr_pops + 1;
        if (b0.rd_req_pop || b0.wr_req_pop) begin
            seq0 <= {seq0[14:0], b0.wr_req_pop};
            n0   <= n0 + 1;
        end
        if (b1.rd_req_pop || b1.wr_req_pop) begin
            seq1 <= {seq1[14:0], b1.wr_req_pop};
            n1   <= n1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b0.wr_req_empty = 1'b1;
        b0.wr_req_addr  = '0;
        b0.wr_req_data  = '0;
        b0.wr_req_be    = '0;
        b0.rd_req_empty = 1'b1;
        b0.rd_req_addr  = '0;
        b0.rd_rsp_free  = 5'd16;
        b0.app_rdy      = 1'b0;
        b0.app_wdf_rdy  = 1'b0;
        b0.app_rd_data  = '0;
        rv_man          = 1'b0;
        auto_en         = 1'b0;
        en              = 1'b1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_app_en", b0.app_en, 0);
        chk("rst_wren", b0.app_wdf_wren, 0);
        chk("rst_rsp_valid", b0.rd_rsp_valid, 0);
        chk("rst_out", out0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
    endtask

    task automatic rd_issue(input logic [31:0] a);
        b0.rd_req_empty = 1'b0;
        b0.rd_req_addr  = a;
        #1 chk("rd_pop", b0.rd_req_pop, 1);
        tick();
        b0.rd_req_empty = 1'b1;
        tick();
    endtask

    task automatic ret(input logic [127:0] d, input logic [31:0] a, input logic [3:0] o);
        rv_man         = 1'b1;
        b0.app_rd_data = d;
        tick();
        rv_man = 1'b0;
        chk("ret_valid", b0.rd_rsp_valid, 1);
        chk("ret_addr", b0.rd_rsp_addr, a);
        chk("ret_data", b0.rd_rsp_data, d);
        chk("ret_out", out0, o);
    endtask

    initial begin
        // single write with delayed write-data accept
        do_reset();
        base0 = wr_pops;
        b0.wr_req_empty = 1'b0;
        b0.wr_req_addr  = 32'h100;
        b0.wr_req_data  = {16{8'hA5}};
        b0.wr_req_be    = 16'h000F;
        b0.app_rdy      = 1'b1;
        #1 chk("wr_pop", b0.wr_req_pop, 1);
        tick();
        b0.wr_req_empty = 1'b1;
        #1;
        chk("wr_app_en", b0.app_en, 1);
        chk("wr_wren", b0.app_wdf_wren, 1);
        chk("wr_end", b0.app_wdf_end, 1);
        chk("wr_mask", b0.app_wdf_mask, 16'hFFF0);
        chk("wr_data", b0.app_wdf_data, {16{8'hA5}});
        chk("wr_addr", b0.app_addr, 29'h100);
        chk("wr_cmd", b0.app_cmd, 3'b000);
        tick();
        chk("wr_en_drop", b0.app_en, 0);
        chk("wr_wren_hold2", b0.app_wdf_wren, 1);
        tick();
        chk("wr_wren_hold3", b0.app_wdf_wren, 1);
        chk("wr_busy", busy0, 1);
        b0.app_wdf_rdy = 1'b1;
        tick();
        chk("wr_wren_drop", b0.app_wdf_wren, 0);
        chk("wr_idle", busy0, 0);
        chk("wr_pop_count", wr_pops - base0, 1);

        // single read, return five cycles later
        do_reset();
        b0.app_rdy = 1'b1;
        b0.rd_req_empty = 1'b0;
        b0.rd_req_addr  = 32'h40;
        #1 chk("rd_pop", b0.rd_req_pop, 1);
        tick();
        b0.rd_req_empty = 1'b1;
        #1;
        chk("rd_app_en", b0.app_en, 1);
        chk("rd_cmd", b0.app_cmd, 3'b001);
        chk("rd_addr", b0.app_addr, 29'h40);
        chk("rd_out0", out0, 0);
        tick();
        chk("rd_en_drop", b0.app_en, 0);
        chk("rd_out1", out0, 1);
        repeat (3) tick();
        chk("rd_no_rsp", b0.rd_rsp_valid, 0);
        ret(128'h1234, 32'h40, 4'd0);
        tick();
        chk("rd_rsp_pulse", b0.rd_rsp_valid, 0);
        chk("rd_idle", busy0, 0);

        // arbitration with both FIFOs non-empty: d0 starve limit, d1 alternation
        do_reset();
        b0.rd_req_empty = 1'b0;
        b0.rd_req_addr  = 32'h80;
        b0.wr_req_empty = 1'b0;
        b0.wr_req_addr  = 32'h200;
        b0.app_rdy      = 1'b1;
        b0.app_wdf_rdy  = 1'b1;
        auto_en         = 1'b1;
        base0 = n0;
        base1 = n1;
        repeat (20) tick();
        b0.rd_req_empty = 1'b1;
        b0.wr_req_empty = 1'b1;
        repeat (3) tick();
        auto_en = 1'b0;
        chk("m0_grants", n0 - base0, 10);
        chk("m0_seq", seq0[9:0], 10'h021);
        chk("m0_err", err0, 0);
        chk("m1_grants", n1 - base1, 10);
        chk("m1_seq", seq1[9:0], 10'h155);

        // response FIFO space limits reads, writes continue
        do_reset();
        b0.rd_rsp_free  = 5'd2;
        b0.rd_req_empty = 1'b0;
        b0.wr_req_empty = 1'b0;
        b0.app_rdy      = 1'b1;
        b0.app_wdf_rdy  = 1'b1;
        base1 = n1;
        repeat (16) tick();
        b0.rd_req_empty = 1'b1;
        b0.wr_req_empty = 1'b1;
        repeat (2) tick();
        chk("free_grants", n1 - base1, 8);
        chk("free_seq", seq1[7:0], 8'h5F);
        chk("free_out1", out1, 2);
        chk("free_out0", out0, 2);

        // in-order tags, return coinciding with a read accept
        do_reset();
        b0.app_rdy = 1'b1;
        rd_issue(32'h10);
        rd_issue(32'h20);
        rd_issue(32'h30);
        chk("tag_out3", out0, 3);
        ret(128'hD1, 32'h10, 4'd2);
        b0.rd_req_empty = 1'b0;
        b0.rd_req_addr  = 32'h40;
        tick();
        b0.rd_req_empty = 1'b1;
        ret(128'hD2, 32'h20, 4'd2);
        ret(128'hD3, 32'h30, 4'd1);
        ret(128'hD4, 32'h40, 4'd0);
        tick();
        chk("tag_done", b0.rd_rsp_valid, 0);

        // return with nothing outstanding
        do_reset();
        rv_man = 1'b1;
        tick();
        rv_man = 1'b0;
        chk("perr_valid", b0.rd_rsp_valid, 0);
        chk("perr_set", err0, 1);
        chk("perr_out", out0, 0);
        repeat (3) tick();
        chk("perr_sticky", err0, 1);

        // en dropped during WR_ISSUE
        do_reset();
        base0 = wr_pops;
        b0.wr_req_empty = 1'b0;
        b0.wr_req_addr  = 32'h300;
        tick();
        en = 1'b0;
        repeat (2) tick();
        chk("en_hold_app_en", b0.app_en, 1);
        chk("en_hold_wren", b0.app_wdf_wren, 1);
        b0.app_rdy     = 1'b1;
        b0.app_wdf_rdy = 1'b1;
        tick();
        chk("en_app_en_done", b0.app_en, 0);
        chk("en_wren_done", b0.app_wdf_wren, 0);
        repeat (3) tick();
        chk("en_pops", wr_pops - base0, 1);
        chk("en_idle", busy0, 0);

        // asynchronous reset in RD_ISSUE
        do_reset();
        b0.rd_req_empty = 1'b0;
        b0.rd_req_addr  = 32'h40;
        tick();
        b0.rd_req_empty = 1'b1;
        chk("ar_app_en", b0.app_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_app_en_clr", b0.app_en, 0);
        chk("ar_cmd", b0.app_cmd, 0);
        chk("ar_addr", b0.app_addr, 0);
        chk("ar_busy", busy0, 0);
        tick();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
